serial_rx_fifo: RTL and testbench
=================================

# serial_rx_fifo

Parametrised receive path for the EMC08 serial port. It supports 8051-style mode 0 (synchronous shift) and modes 1/2/3 (asynchronous, 16x oversampled) with a configurable data width, multiprocessor SM2 filtering, frame and overrun error flags, and a receive FIFO. It sits between the baud-rate generator / P3 pins and the SBUF/SCON register interface, and is the successor of the fixed 8-bit single-buffer receiver.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (5..9 legal; mode 0 always shifts DATA_W bits)
- FIFO_DEPTH, 4, receive FIFO entries, power of two, >= 2

Ports:
- serial_clock_i  in  1  system clock, all logic on rising edge
- serial_reset_i_b  in  1  asynchronous, active-low reset
- serial_br_i  in  1  baud tick, one-clock pulse; 1/16 bit time in modes 1-3, half bit time in mode 0
- serial_rxd_data_i  in  1  RXD pin (asynchronous; internally double-flopped)
- serial_scon_mode_i  in  2  {SM0,SM1}: 00 mode 0, 01 mode 1, 10 mode 2, 11 mode 3
- serial_scon4_ren_i  in  1  receive enable
- serial_scon5_sm2_i  in  1  multiprocessor filter enable
- serial_rd_i  in  1  pop FIFO head (ignored when empty)
- serial_err_clr_i  in  1  clears fe/ovr flags
- serial_sbuf_rx_o  out  DATA_W  FIFO head data
- serial_rb8_o  out  1  FIFO head 9th bit (mode 2/3) or stop bit (mode 1); 0 in mode 0
- serial_ri_o  out  1  FIFO non-empty
- serial_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO fill level
- serial_fe_o  out  1  sticky frame error
- serial_ovr_o  out  1  sticky overrun
- serial_shift_clk_o  out  1  mode 0 shift clock driven to TXD

## Operation
- Receive FSM states: IDLE, M0_SHIFT, START, DATA, BIT9, STOP.
- IDLE, mode 0: on REN=1 and FIFO not full, go to M0_SHIFT. serial_shift_clk_o toggles on each br tick, low phase first. RXD is sampled on the tick that drives the clock high. Bits arrive LSB first. After DATA_W bits, the word is pushed with rb8=0 and the clock idles high. If REN is still 1, the next word starts on the next tick.
- IDLE, modes 1-3: a synchronised 1->0 on RXD with REN=1 enters START and resets the 4-bit sample counter.
- Bit decision is taken at sample 9 of each bit (see Configuration).
  - START: a decision of 1 is a false start; return to IDLE.
  - DATA: shifts DATA_W bits LSB first.
  - BIT9: entered in modes 2/3 only.
  - STOP: decides the stop bit, then returns to IDLE at once. There is no wait for end of stop.
- Frame acceptance at the STOP decision:
  - stop=0: set fe, discard the frame.
  - mode 2/3 with SM2=1 and bit9=0: discard silently.
  - FIFO full (after any same-cycle pop): set ovr, discard.
  - otherwise: push {rb8, data}.
- FIFO: push at tail, pop at head. Same-cycle push+pop is legal at every level. When full, the pop frees a slot, so the push is accepted and no overrun is flagged.
- REN falling, or any change of serial_scon_mode_i, mid-frame: abort to IDLE with no push and no flag. serial_shift_clk_o returns to 1.
- fe/ovr: set has priority over serial_err_clr_i in the same cycle.

## Timing
- Reset values: sbuf 0, rb8 0, ri 0, count 0, fe 0, ovr 0, shift_clk 1, FSM IDLE, FIFO empty.
- RXD synchroniser adds 2 clocks before start detection.
- Push latency: FIFO outputs and ri update one clock after the br tick carrying the STOP decision (mode 0: after the DATA_W-th sampling tick).
- Pop: head, count and ri update the clock after serial_rd_i=1.
- fe/ovr assert the same clock the frame would have been pushed.

## Configuration
- SERIAL_RX_MAJORITY_EN defined: each bit value is the 2-of-3 majority of samples 7, 8 and 9. This applies to the start-bit check.
- SERIAL_RX_MAJORITY_EN undefined: each bit value is sample 8 alone, still registered at sample 9. The sample shift register logic is removed.

## Test plan
- Mode 0, DATA_W=8, REN=1, RXD patterns 8'hFC, 8'hFF, 8'h00, 8'hAA, 8'h55 -> sbuf matches each in order, rb8=0, shift_clk produces 8 low pulses per word.
- Mode 1, frame 0x3C with stop=1 -> ri=1, sbuf=0x3C, rb8=1, count=1. The same frame with stop=0 -> fe=1, count unchanged.
- Mode 1, a 4-sample low glitch on RXD -> false start, FSM back in IDLE, no push, fe=0.
- Mode 3, SM2=1, frames {bit9=0, 0x11} and {bit9=1, 0x22} -> only 0x22 pushed, rb8=1.
- FIFO_DEPTH=4: push 5 frames without rd -> count=4, ovr=1, head=frame 1. Repeat with rd asserted on the 5th push cycle -> ovr=0, count=4.
- REN dropped mid-DATA, then async reset asserted mid-frame -> no push. After reset, all outputs are at their reset values and shift_clk=1.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: EMC08 serial receive path.
// Mode 0 synchronous shift, modes 1/2/3 asynchronous 16x oversampled,
// SM2 multiprocessor filter, sticky frame/overrun flags, receive FIFO.
// Optional build macro SERIAL_RX_MAJORITY_EN: each bit is the 2-of-3
// majority of samples 7, 8 and 9 instead of sample 8 alone.
//
// Read handshake: serial_ri_o acts as "valid" for the FIFO head
// (serial_sbuf_rx_o / serial_rb8_o); serial_rd_i is a one-cycle "ready"
// that consumes the head on the clock edge where both are 1. A serial_rd_i
// pulse while the FIFO is empty is ignored.
module serial_rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            serial_clock_i,
   input  logic                            serial_reset_i_b,
   input  logic                            serial_br_i,
   input  logic                            serial_rxd_data_i,
   input  logic [1:0]                      serial_scon_mode_i,
   input  logic                            serial_scon4_ren_i,
   input  logic                            serial_scon5_sm2_i,
   input  logic                            serial_rd_i,
   input  logic                            serial_err_clr_i,
   output logic [DATA_W-1:0]               serial_sbuf_rx_o,
   output logic                            serial_rb8_o,
   output logic                            serial_ri_o,
   output logic [$clog2(FIFO_DEPTH):0]     serial_count_o,
   output logic                            serial_fe_o,
   output logic                            serial_ovr_o,
   output logic                            serial_shift_clk_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] M0_SHIFT = 3'd1;
   localparam logic [2:0] START    = 3'd2;
   localparam logic [2:0] DATA     = 3'd3;
   localparam logic [2:0] BIT9     = 3'd4;
   localparam logic [2:0] STOP     = 3'd5;

   logic              rxd_meta_q, rxd_sync_q, rxd_prev_q;
   logic [2:0]        state_q;
   logic [1:0]        mode_q;
   logic [3:0]        smp_cnt_q;
   logic [3:0]        bit_cnt_q;
   logic [DATA_W-1:0] shreg_q;
   logic              bit9_q;
   logic              shift_clk_q;

   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic [DATA_W:0]   mem_q [FIFO_DEPTH];
   logic              fe_q, ovr_q;

   logic              bit_val, decide, abort, last_bit, full, pop;
   logic              m0_push, stop_decide, frame_ok, fe_set, push_req, push_ok, ovr_set;
   logic [DATA_W:0]   push_data, head;

   // Two-flop synchroniser for RXD plus one stage of history for edge detect
   always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
      if (!serial_reset_i_b) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= serial_rxd_data_i;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

`ifdef SERIAL_RX_MAJORITY_EN
   logic [1:0] smp_hist_q;

   // Keep the last two samples so samples 7 and 8 are on hand at sample 9
   always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
      if (!serial_reset_i_b) smp_hist_q <= 2'b11;
      else if (serial_br_i)  smp_hist_q <= {smp_hist_q[0], rxd_sync_q};
   end

   assign bit_val = (smp_hist_q[1] & smp_hist_q[0]) |
                    (smp_hist_q[1] & rxd_sync_q)    |
                    (smp_hist_q[0] & rxd_sync_q);
`else
   logic smp8_q;

   // Capture sample 8; the bit is acted on one tick later at sample 9
   always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
      if (!serial_reset_i_b)                       smp8_q <= 1'b1;
      else if (serial_br_i && smp_cnt_q == 4'd8)   smp8_q <= rxd_sync_q;
   end

   assign bit_val = smp8_q;
`endif

   assign decide   = serial_br_i && (smp_cnt_q == 4'd9);
   assign abort    = (state_q != IDLE) &&
                     (!serial_scon4_ren_i || (serial_scon_mode_i != mode_q));
   assign last_bit = (bit_cnt_q == 4'(DATA_W - 1));
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign pop      = serial_rd_i && (count_q != '0);

   assign m0_push     = (state_q == M0_SHIFT) && serial_br_i && !shift_clk_q && last_bit && !abort;
   assign stop_decide = (state_q == STOP) && decide && !abort;
   assign frame_ok    = stop_decide && bit_val && !(mode_q[1] && serial_scon5_sm2_i && !bit9_q);
   assign fe_set      = stop_decide && !bit_val;
   assign push_req    = m0_push || frame_ok;
   // A pop in the same cycle frees the slot a full FIFO needs
   assign push_ok     = push_req && (!full || pop);
   assign ovr_set     = push_req && full && !pop;

   // Word entering the FIFO: mode 0 completes with the live RXD sample
   always_comb begin
      push_data = {1'b0, rxd_sync_q, shreg_q[DATA_W-1:1]};
      if (state_q != M0_SHIFT) push_data = {(mode_q[1] ? bit9_q : 1'b1), shreg_q};
   end

   // Receive FSM: mode 0 shifter and oversampled asynchronous frame decoder
   always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
      if (!serial_reset_i_b) begin
         state_q     <= IDLE;
         mode_q      <= 2'b00;
         smp_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         bit9_q      <= 1'b0;
         shift_clk_q <= 1'b1;
      end else begin
         mode_q <= serial_scon_mode_i;
         if (abort) begin
            state_q     <= IDLE;
            shift_clk_q <= 1'b1;
         end else begin
            if (serial_br_i) smp_cnt_q <= smp_cnt_q + 4'd1;
            case (state_q)
               IDLE: begin
                  shift_clk_q <= 1'b1;
                  if (serial_scon4_ren_i) begin
                     if (serial_scon_mode_i == 2'b00) begin
                        if (!full) begin
                           state_q   <= M0_SHIFT;
                           bit_cnt_q <= '0;
                        end
                     end else if (rxd_prev_q && !rxd_sync_q) begin
                        state_q   <= START;
                        smp_cnt_q <= '0;
                     end
                  end
               end
               M0_SHIFT: begin
                  if (serial_br_i) begin
                     if (shift_clk_q) begin
                        shift_clk_q <= 1'b0;
                     end else begin
                        shift_clk_q <= 1'b1;
                        shreg_q     <= {rxd_sync_q, shreg_q[DATA_W-1:1]};
                        bit_cnt_q   <= bit_cnt_q + 4'd1;
                        if (last_bit) state_q <= IDLE;
                     end
                  end
               end
               START: begin
                  if (decide) begin
                     bit_cnt_q <= '0;
                     state_q   <= bit_val ? IDLE : DATA;
                  end
               end
               DATA: begin
                  if (decide) begin
                     shreg_q   <= {bit_val, shreg_q[DATA_W-1:1]};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (last_bit) state_q <= mode_q[1] ? BIT9 : STOP;
                  end
               end
               BIT9: begin
                  if (decide) begin
                     bit9_q  <= bit_val;
                     state_q <= STOP;
                  end
               end
               STOP: begin
                  if (decide) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // FIFO storage: no reset needed, the head is masked while empty
   always_ff @(posedge serial_clock_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   // FIFO pointers, fill level and sticky error flags (set beats clear)
   always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
      if (!serial_reset_i_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         fe_q     <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         fe_q  <= fe_set  | (fe_q  & ~serial_err_clr_i);
         ovr_q <= ovr_set | (ovr_q & ~serial_err_clr_i);
      end
   end

   assign head               = mem_q[rd_ptr_q];
   assign serial_ri_o        = (count_q != '0);
   assign serial_sbuf_rx_o   = serial_ri_o ? head[DATA_W-1:0] : '0;
   assign serial_rb8_o       = serial_ri_o ? head[DATA_W] : 1'b0;
   assign serial_count_o     = count_q;
   assign serial_fe_o        = fe_q;
   assign serial_ovr_o       = ovr_q;
   assign serial_shift_clk_o = shift_clk_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo: directed bench for serial_rx_fifo (DATA_W=8, FIFO_DEPTH=4).
module tb_serial_rx_fifo;

   localparam logic [2:0] ST_IDLE = 3'd0;

   logic       clk = 1'b0;
   logic       rst_n, br, rxd, ren, sm2, rd, err_clr;
   logic [1:0] mode;
   logic [7:0] sbuf;
   logic       rb8, ri, fe, ovr, shift_clk;
   logic [2:0] count;
   int         checks = 0;
   int         failures = 0;
   int         lows;

   serial_rx_fifo #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
      .serial_clock_i     (clk),
      .serial_reset_i_b   (rst_n),
      .serial_br_i        (br),
      .serial_rxd_data_i  (rxd),
      .serial_scon_mode_i (mode),
      .serial_scon4_ren_i (ren),
      .serial_scon5_sm2_i (sm2),
      .serial_rd_i        (rd),
      .serial_err_clr_i   (err_clr),
      .serial_sbuf_rx_o   (sbuf),
      .serial_rb8_o       (rb8),
      .serial_ri_o        (ri),
      .serial_count_o     (count),
      .serial_fe_o        (fe),
      .serial_ovr_o       (ovr),
      .serial_shift_clk_o (shift_clk)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One baud tick, optionally with a FIFO pop in the same clock
   task automatic tick(input logic rd_too);
      repeat (4) @(negedge clk);
      br = 1'b1;
      rd = rd_too;
      @(negedge clk);
      br = 1'b0;
      rd = 1'b0;
   endtask

   // One asynchronous bit time: 16 ticks, pop on tick index rd_at if >= 0
   task automatic rx_bit(input logic v, input int rd_at);
      rxd = v;
      for (int t = 0; t < 16; t++) tick(t == rd_at);
   endtask

   task automatic frame(input logic [7:0] d, input logic use_b9, input logic b9,
                        input logic stop, input logic pop_on_stop);
      rx_bit(1'b0, -1);
      for (int i = 0; i < 8; i++) rx_bit(d[i], -1);
      if (use_b9) rx_bit(b9, -1);
      rx_bit(stop, pop_on_stop ? 9 : -1);
      rxd = 1'b1;
   endtask

   task automatic pop_one();
      @(negedge clk);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   // Mode 0 word: low tick, present bit, high (sampling) tick
   task automatic m0_word(input logic [7:0] w);
      lows = 0;
      for (int i = 0; i < 8; i++) begin
         tick(1'b0);
         if (shift_clk === 1'b0) lows++;
         rxd = w[i];
         tick(1'b0);
      end
      check("m0_sbuf", sbuf, w);
      check("m0_rb8", rb8, 0);
      check("m0_count", count, 1);
      check("m0_low_pulses", lows, 8);
      check("m0_clk_idle", shift_clk, 1);
      pop_one();
      check("m0_pop_count", count, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sbuf"}, sbuf, 0);
      check({tag, "_rb8"}, rb8, 0);
      check({tag, "_ri"}, ri, 0);
      check({tag, "_count"}, count, 0);
      check({tag, "_fe"}, fe, 0);
      check({tag, "_ovr"}, ovr, 0);
      check({tag, "_shift_clk"}, shift_clk, 1);
      check({tag, "_state"}, dut.state_q, ST_IDLE);
   endtask

   initial begin
      // Reset
      rst_n = 1'b0; br = 1'b0; rxd = 1'b1; mode = 2'b00; ren = 1'b0;
      sm2 = 1'b0; rd = 1'b0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Mode 0 words
      ren = 1'b1;
      m0_word(8'hFC);
      m0_word(8'hFF);
      m0_word(8'h00);
      m0_word(8'hAA);
      m0_word(8'h55);
      // Abort mode 0 mid-word with clock low
      tick(1'b0);
      check("m0_clk_low", shift_clk, 0);
      ren = 1'b0;
      repeat (2) @(negedge clk);
      check("m0_abort_clk", shift_clk, 1);
      check("m0_abort_state", dut.state_q, ST_IDLE);
      check("m0_abort_count", count, 0);

      // Mode 1 good frame then framing error
      rxd = 1'b1;
      mode = 2'b01;
      repeat (5) @(negedge clk);
      ren = 1'b1;
      frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
      check("m1_ri", ri, 1);
      check("m1_sbuf", sbuf, 8'h3C);
      check("m1_rb8", rb8, 1);
      check("m1_count", count, 1);
      check("m1_fe0", fe, 0);
      frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      check("m1_fe", fe, 1);
      check("m1_fe_count", count, 1);
      check("m1_fe_sbuf", sbuf, 8'h3C);
      clear_err();
      check("m1_fe_clr", fe, 0);
      pop_one();
      check("m1_pop_ri", ri, 0);
      check("m1_pop_sbuf", sbuf, 0);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      check("m1_pop_empty_count", count, 0);

      // False start: 4-sample low glitch
      rxd = 1'b0;
      for (int t = 0; t < 4; t++) tick(1'b0);
      rxd = 1'b1;
      for (int t = 0; t < 12; t++) tick(1'b0);
      check("glitch_state", dut.state_q, ST_IDLE);
      check("glitch_count", count, 0);
      check("glitch_fe", fe, 0);

      // Mode 3 with SM2: only the address frame (bit9=1) is kept
      mode = 2'b11;
      sm2 = 1'b1;
      repeat (5) @(negedge clk);
      frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
      frame(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
      check("sm2_count", count, 1);
      check("sm2_sbuf", sbuf, 8'h22);
      check("sm2_rb8", rb8, 1);
      pop_one();
      sm2 = 1'b0;
      // Mode 2 data frame without SM2 keeps bit9=0 in rb8
      mode = 2'b10;
      repeat (5) @(negedge clk);
      frame(8'h96, 1'b1, 1'b0, 1'b1, 1'b0);
      check("m2_sbuf", sbuf, 8'h96);
      check("m2_rb8", rb8, 0);
      pop_one();

      // Overrun: five frames into a four-entry FIFO
      mode = 2'b01;
      repeat (5) @(negedge clk);
      for (int k = 0; k < 5; k++) frame(8'hA1 + 8'(k), 1'b0, 1'b0, 1'b1, 1'b0);
      check("ovr_count", count, 4);
      check("ovr_flag", ovr, 1);
      check("ovr_head", sbuf, 8'hA1);
      clear_err();
      check("ovr_clr", ovr, 0);
      for (int k = 0; k < 4; k++) begin
         check("ovr_drain", sbuf, 8'hA1 + 8'(k));
         pop_one();
      end
      check("ovr_drained", count, 0);

      // Same with a pop on the fifth push cycle
      for (int k = 0; k < 5; k++) frame(8'hB1 + 8'(k), 1'b0, 1'b0, 1'b1, k == 4);
      check("pp_ovr", ovr, 0);
      check("pp_count", count, 4);
      check("pp_head", sbuf, 8'hB2);
      for (int k = 0; k < 4; k++) begin
         check("pp_drain", sbuf, 8'hB2 + 8'(k));
         pop_one();
      end
      check("pp_drained", count, 0);

      // Mode change mid-frame aborts
      rx_bit(1'b0, -1);
      rx_bit(1'b1, -1);
      mode = 2'b11;
      repeat (2) @(negedge clk);
      check("mchg_state", dut.state_q, ST_IDLE);
      mode = 2'b01;
      rxd = 1'b1;
      for (int t = 0; t < 16; t++) tick(1'b0);
      check("mchg_count", count, 0);

      // REN dropped mid-DATA, rest of the frame still arrives
      rx_bit(1'b0, -1);
      rx_bit(1'b1, -1);
      rx_bit(1'b0, -1);
      ren = 1'b0;
      repeat (2) @(negedge clk);
      check("ren_state", dut.state_q, ST_IDLE);
      for (int i = 0; i < 6; i++) rx_bit(1'b1, -1);
      rx_bit(1'b1, -1);
      check("ren_count", count, 0);
      check("ren_fe", fe, 0);

      // Async reset mid-frame with data and fe pending
      ren = 1'b1;
      frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      check("pre_rst_count", count, 1);
      check("pre_rst_fe", fe, 1);
      rx_bit(1'b0, -1);
      rx_bit(1'b1, -1);
      rx_bit(1'b0, -1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      repeat (2) @(negedge clk);
      rxd = 1'b1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_reset_outputs("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
